// File: rtl/data_mem_be_if.sv
// Bus bundle for data_mem_be: request side (req, wr_rd, size, sign_ext,
// addr, data_in) and response side (data_out, rd_valid, misalign, busy).
//   master : drives requests, observes responses (testbench / CPU side)
//   slave  : the memory itself
interface data_mem_be_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              wr_rd;     // 1 = read, 0 = write
  logic [1:0]        size;      // 00 byte, 01 half, 10 word, 11 reserved
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              rd_valid;
  logic              misalign;
  logic              busy;

  modport master (
    output req, wr_rd, size, sign_ext, addr, data_in,
    input  data_out, rd_valid, misalign, busy
  );

  modport slave (
    input  req, wr_rd, size, sign_ext, addr, data_in,
    output data_out, rd_valid, misalign, busy
  );
endinterface

// File: rtl/data_mem_be.sv
// Byte-enabled 32-bit data memory with a zero-clear sweep after reset.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; restarts the clear sweep
//   bus  - data_mem_be_if.slave: little-endian byte/half/word accesses,
//          registered read data (latency 1) with rd_valid pulse,
//          misalign pulse on rejected accesses, busy during the sweep.
module data_mem_be #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12
) (
  input logic          clk,
  input logic          rst,
  data_mem_be_if.slave bus
);
  localparam int IW = ADDR_W - 2;

  typedef enum logic {INIT, IDLE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx;
  logic [31:0]    mem [DEPTH];

  logic [IW-1:0]  word;
  logic [1:0]     lane;
  logic           aligned;
  logic           access;
  logic           wr_en;
  logic           rd_en;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic [31:0]    rd_word;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    rd_ext;

  assign word = bus.addr[ADDR_W-1:2];
  assign lane = bus.addr[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (idx == IW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    bus.busy = (state == INIT);
    access   = bus.req && (state == IDLE);

    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.addr[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase

    wr_en = access && aligned && !bus.wr_rd;
    rd_en = access && aligned &&  bus.wr_rd;

    // Data is replicated across lanes so each enabled lane picks its own slice
    case (bus.size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.data_in[7:0]}};
      end
      2'b01: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.data_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.data_in;
      end
    endcase
  end

  // Read extraction and extension
  always_comb begin
    rd_word = mem[word];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.size)
      2'b00:   rd_ext = bus.sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      2'b01:   rd_ext = bus.sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  // Sweep index; wraps to zero as the sweep completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                idx <= '0;
    else if (state == INIT) idx <= idx + 1'b1;
  end

  // Registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.rd_valid <= rd_en;
      bus.misalign <= access && !aligned;
      if (rd_en) bus.data_out <= rd_ext;
    end
  end

  // Storage: sweep clears one word per cycle, otherwise lane-masked writes
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[idx] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_be.sv
module tb_data_mem_be;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 12;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] ref_dout;

  data_mem_be_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_be #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    ref_dout = '0;
  endtask

  // One request per cycle; called at posedge+1, returns at the next posedge+1.
  task automatic do_op(input string tag, input logic rd, input logic [1:0] sz,
                       input logic sx, input int a, input logic [31:0] d);
    int          n;
    logic        al;
    logic [31:0] v;
    logic [31:0] ones;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    al = (sz != 2'd3) && ((a % n) == 0);
    if (al && !rd) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = d[8*i +: 8];
    end
    if (al && rd) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      ones = '1;
      if (sx && n < 4 && v[8*n-1]) v = v | (ones << (8*n));
      ref_dout = v;
    end
    bus.req      = 1'b1;
    bus.wr_rd    = rd;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = ADDR_W'(a);
    bus.data_in  = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(al && rd));
    chk({tag, ".misalign"}, 32'(bus.misalign), 32'(!al));
    chk({tag, ".data_out"}, bus.data_out, ref_dout);
  endtask

  task automatic idle_cycle();
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("idle.misalign", 32'(bus.misalign), 32'd0);
    chk("idle.data_out", bus.data_out, ref_dout);
  endtask

  // Count cycles until busy drops; rst must already be released.
  task automatic sweep(input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (bus.busy && cnt < 2000);
    chk(tag, 32'(cnt), 32'd1024);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".busy"},     32'(bus.busy),     32'd1);
    chk({tag, ".data_out"}, bus.data_out,      32'd0);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, ".misalign"}, 32'(bus.misalign), 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    bus.req      = 1'b0;
    bus.wr_rd    = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = '0;
    bus.data_in  = '0;
    model_clear();

    // Power-on reset: 10 ns high, then the sweep
    rst = 1'b1;
    #5;
    reset_checks("por");
    #5;
    rst = 1'b0;
    sweep("sweep_len_por");

    // Cleared memory reads zero, latency 1
    for (int i = 0; i < 10; i++) do_op("rd_zero", 1'b1, 2'b10, 1'b0, 4*i, 32'h0);

    // Back-to-back word writes then reads
    for (int i = 0; i < 10; i++) do_op("wr_seq", 1'b0, 2'b10, 1'b0, 4*i, 32'(i));
    for (int i = 0; i < 10; i++) begin
      do_op("rd_seq", 1'b1, 2'b10, 1'b0, 4*i, 32'h0);
      chk("rd_seq.value", bus.data_out, 32'(i));
    end
    idle_cycle();

    // Extraction and extension
    do_op("wr_100", 1'b0, 2'b10, 1'b0, 'h100, 32'h808182F3);
    do_op("sb_100", 1'b1, 2'b00, 1'b1, 'h100, 32'h0);
    chk("sb_100.const", bus.data_out, 32'hFFFFFFF3);
    do_op("ub_103", 1'b1, 2'b00, 1'b0, 'h103, 32'h0);
    chk("ub_103.const", bus.data_out, 32'h00000080);
    do_op("sh_102", 1'b1, 2'b01, 1'b1, 'h102, 32'h0);
    chk("sh_102.const", bus.data_out, 32'hFFFF8081);
    do_op("uh_100", 1'b1, 2'b01, 1'b0, 'h100, 32'h0);
    chk("uh_100.const", bus.data_out, 32'h000082F3);
    do_op("sw_100", 1'b1, 2'b10, 1'b1, 'h100, 32'h0);
    chk("sw_100.const", bus.data_out, 32'h808182F3);

    // Byte write then read on the very next cycle
    do_op("wb_101", 1'b0, 2'b00, 1'b0, 'h101, 32'h123456AA);
    do_op("rw_100", 1'b1, 2'b10, 1'b0, 'h100, 32'h0);
    chk("rw_100.const", bus.data_out, 32'h8081AAF3);
    do_op("wh_102", 1'b0, 2'b01, 1'b0, 'h102, 32'hBEEF5A5A);
    do_op("rw_100b", 1'b1, 2'b10, 1'b0, 'h100, 32'h0);
    chk("rw_100b.const", bus.data_out, 32'h5A5AAAF3);

    // Rejected accesses
    do_op("mis_ww002", 1'b0, 2'b10, 1'b0, 'h002, 32'hFFFFFFFF);
    do_op("mis_rh001", 1'b1, 2'b01, 1'b0, 'h001, 32'h0);
    do_op("mis_rsz11", 1'b1, 2'b11, 1'b0, 'h000, 32'h0);
    do_op("mis_wsz11", 1'b0, 2'b11, 1'b0, 'h004, 32'hFFFFFFFF);
    do_op("mis_after", 1'b1, 2'b10, 1'b0, 'h000, 32'h0);
    chk("mis_after.const", bus.data_out, 32'h0);

    // Randomised traffic on a small window so reads hit written data
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      else do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom);
    end
    do_op("pre_rst", 1'b1, 2'b10, 1'b0, 'h100, 32'h0);

    // Reset mid-operation, then again mid-sweep
    rst = 1'b1;
    #2;
    model_clear();
    reset_checks("rst_op");
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    bus.req     = 1'b1;
    bus.wr_rd   = 1'b0;
    bus.size    = 2'b10;
    bus.addr    = ADDR_W'('h010);
    bus.data_in = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    chk("busy_wr.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("busy_wr.misalign", 32'(bus.misalign), 32'd0);
    chk("busy_wr.busy",     32'(bus.busy),     32'd1);
    repeat (199) @(posedge clk);
    #1;
    chk("mid_sweep.busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #2;
    reset_checks("rst_sweep");
    @(negedge clk);
    rst = 1'b0;
    sweep("sweep_len_restart");
    do_op("rd_010", 1'b1, 2'b10, 1'b0, 'h010, 32'h0);
    chk("rd_010.const", bus.data_out, 32'h0);
    for (int i = 0; i < 10; i++) do_op("rd_clr", 1'b1, 2'b10, 1'b0, 4*i, 32'h0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, meaning number of 32-bit words and a power of two.
REQ-002 SHALL provide parameter ADDR_W, default 12, meaning byte-address width, equal to log2(DEPTH)+2.
REQ-003 SHALL provide port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port req  input  1  access request, sampled on rising edge.
REQ-006 SHALL provide port wr_rd  input  1  1 = read, 0 = write.
REQ-007 SHALL provide port size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-008 SHALL provide port sign_ext  input  1  reads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL provide port addr  input  ADDR_W  byte address.
REQ-010 SHALL provide port data_in  input  32  write data, right-aligned.
REQ-011 SHALL provide port data_out  output  32  registered, extended read data.
REQ-012 SHALL provide port rd_valid  output  1  one-cycle pulse marking new data_out.
REQ-013 SHALL provide port misalign  output  1  one-cycle pulse on a rejected access.
REQ-014 SHALL provide port busy  output  1  high while the clear sweep runs.

Function
REQ-015 SHALL map the word index to addr[ADDR_W-1:2] and the byte lane to addr[1:0], little-endian, with lane 0 as bits 7:0.
REQ-016 SHALL implement states INIT (clear sweep) and IDLE (serving requests), and SHALL use no other states.
REQ-017 SHALL, in INIT, write zero to one word per cycle, indices 0 to DEPTH-1, hold busy=1, then enter IDLE with busy=0 on the cycle after index DEPTH-1 is cleared.
REQ-018 SHALL ignore req while busy=1: no memory change, no rd_valid, no misalign.
REQ-019 SHALL treat an access as aligned when size=00, or size=01 with addr[0]=0, or size=10 with addr[1:0]=00; size=11 is never aligned.
REQ-020 SHALL, on an aligned write in IDLE, update only the addressed lanes at the same rising edge: byte writes data_in[7:0]; half writes data_in[15:0] to lanes {addr[1],0} and {addr[1],1}; word writes all 32 bits.
REQ-021 SHALL, on an aligned read in IDLE, register the extracted byte, half or word, extended per sign_ext, into data_out and assert rd_valid=1 on the next rising edge, giving latency 1.
REQ-022 SHALL ignore sign_ext for word reads.
REQ-023 SHALL hold data_out unchanged except on an aligned read.
REQ-024 SHALL return newly written data for a read issued in the cycle after a write to the same word.
REQ-025 SHALL, for a misaligned or size=11 access (read or write) in IDLE, leave memory unchanged, keep rd_valid=0, keep data_out unchanged, and pulse misalign=1 on the next edge.
REQ-026 SHALL deassert rd_valid and misalign in any cycle that follows no qualifying request.
REQ-027 SHALL accept back-to-back requests every cycle with no stall.

Reset
REQ-028 SHALL, while rst=1, force data_out=0, rd_valid=0, misalign=0, busy=1, state=INIT and sweep index=0, asynchronously.
REQ-029 SHALL, on reassertion of rst mid-sweep or mid-operation, abandon the current operation and restart the full DEPTH-cycle sweep after release.
REQ-030 SHALL guarantee that all memory reads as zero after every completed sweep.

Verification
REQ-031 SHALL cover: rst high for 10 ns then low, clk period 20 ns -> busy=1 for exactly 1024 cycles; word reads at 0x000 to 0x024 -> data_out=0 with rd_valid one cycle after each request.
REQ-032 SHALL cover: word writes of 0 to 9 at 0x000, 0x004, ..., 0x024 back-to-back, then reads -> values 0 to 9 in order, each at latency 1.
REQ-033 SHALL cover: word write 0x808182F3 at 0x100 -> signed byte read at 0x100 = 0xFFFFFFF3; unsigned byte read at 0x103 = 0x00000080; signed half read at 0x102 = 0xFFFF8081; unsigned half read at 0x100 = 0x000082F3.
REQ-034 SHALL cover: byte write 0xAA at 0x101 after REQ-033 -> word read at 0x100 = 0x8081AAF3; write then read on the next cycle -> new value.
REQ-035 SHALL cover: word write at 0x002, half read at 0x001, and size=11 read -> misalign=1 each, rd_valid=0, data_out unchanged, word at 0x000 unchanged.
REQ-036 SHALL cover: rst pulsed at sweep cycle 500, and a write to 0x010 issued while busy=1 -> busy=1 for a full 1024 cycles after release; 0x010 reads 0.
